snake_grid_scan: RTL and testbench

Downstream consumer of the snake core's game state (Food, Length, Locations_Flat). On request it snapshots that state and streams a row-major classification of all 256 grid cells to the display driver. Cells are EMPTY, BODY, HEAD or FOOD, delivered over a valid/ready handshake. Decouples display timing from the core's state updates, so a frame is never torn mid-scan.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/snake_cell_classify.sv | 52 +++++
 rtl/snake_grid_scan.sv | 133 +++++++++++++
 tb/tb_snake_grid_scan.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake core and the grid scanner.
// Cell codes, scan FSM states, grid geometry constants and direction codes.
package snake_pkg;

   localparam int LOC_W     = 8;
   localparam int NUM_SEG   = 16;
   localparam int NUM_CELLS = 2**LOC_W;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BODY  = 2'd1,
      CELL_HEAD  = 2'd2,
      CELL_FOOD  = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } scan_state_t;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_t;

endpackage

// File: rtl/snake_cell_classify.sv
// Combinational classification of one grid cell against a snake/food snapshot.
// With SNAKE_SCAN_OVERLAP_EN defined it also flags cells hit by two or more segments.
module snake_cell_classify
   import snake_pkg::*;
(
   input  logic [LOC_W-1:0]         i_addr,
   input  logic [3:0]               i_len,
   input  logic [LOC_W-1:0]         i_food,
   input  logic [NUM_SEG*LOC_W-1:0] i_locs,
`ifdef SNAKE_SCAN_OVERLAP_EN
   output logic                     o_multi,
`endif
   output logic [1:0]               o_type
);

   logic             w_body_hit;
   logic [4:0]       w_hits;
   logic [LOC_W-1:0] w_head;
   logic             w_seg_hit;

   assign w_head = i_locs[NUM_SEG*LOC_W-1 -: LOC_W];

   // Segment i is occupied when i <= length; head (slot 0) is always occupied.
   always_comb begin
      w_body_hit = 1'b0;
      w_hits     = 5'd0;
      w_seg_hit  = 1'b0;
      for (int i = 0; i < NUM_SEG; i++) begin
         w_seg_hit = (4'(i) <= i_len) &&
                     (i_locs[NUM_SEG*LOC_W-1-LOC_W*i -: LOC_W] == i_addr);
         w_hits    = w_hits + {4'd0, w_seg_hit};
         w_body_hit = w_body_hit | (w_seg_hit && (i != 0));
      end
   end

`ifdef SNAKE_SCAN_OVERLAP_EN
   assign o_multi = (w_hits >= 5'd2);
`endif

   always_comb begin
      if (w_head == i_addr) begin
         o_type = CELL_HEAD;
      end else if (i_food == i_addr) begin
         o_type = CELL_FOOD;
      end else if (w_body_hit) begin
         o_type = CELL_BODY;
      end else begin
         o_type = CELL_EMPTY;
      end
   end

endmodule

// File: rtl/snake_grid_scan.sv
// Snapshots the snake game state on Start and streams all 256 cell classifications
// over a valid/ready handshake. Optional macro: SNAKE_SCAN_OVERLAP_EN adds Overlap.
module snake_grid_scan
   import snake_pkg::*;
(
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [3:0]   Length,
   input  logic [7:0]   Food,
   input  logic [127:0] Locations_Flat,
   output logic         Busy,
   output logic         Cell_Valid,
   input  logic         Cell_Ready,
   output logic [7:0]   Cell_Addr,
   output logic [1:0]   Cell_Type,
`ifdef SNAKE_SCAN_OVERLAP_EN
   output logic         Overlap,
`endif
   output logic         Frame_Done
);

   localparam logic [LOC_W-1:0] LAST_ADDR = LOC_W'(NUM_CELLS - 1);

   scan_state_t      r_state;
   logic [3:0]       r_snap_len;
   logic [7:0]       r_snap_food;
   logic [127:0]     r_snap_locs;

   logic [7:0]       w_cls_addr;
   logic [3:0]       w_cls_len;
   logic [7:0]       w_cls_food;
   logic [127:0]     w_cls_locs;
   logic [1:0]       w_type;

   // In IDLE the first cell is classified straight from the live inputs so it
   // can be registered together with the snapshot; afterwards the snapshot
   // drives the lookahead for the next address.
   assign w_cls_addr = (r_state == ST_IDLE) ? 8'd0 : (Cell_Addr + 8'd1);
   assign w_cls_len  = (r_state == ST_IDLE) ? Length : r_snap_len;
   assign w_cls_food = (r_state == ST_IDLE) ? Food : r_snap_food;
   assign w_cls_locs = (r_state == ST_IDLE) ? Locations_Flat : r_snap_locs;

`ifdef SNAKE_SCAN_OVERLAP_EN
   logic w_multi;
   logic r_cur_multi;
   logic r_ovl_flag;
`endif

   snake_cell_classify u_classify (
      .i_addr  (w_cls_addr),
      .i_len   (w_cls_len),
      .i_food  (w_cls_food),
      .i_locs  (w_cls_locs),
`ifdef SNAKE_SCAN_OVERLAP_EN
      .o_multi (w_multi),
`endif
      .o_type  (w_type)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_snap_len  <= 4'd0;
         r_snap_food <= 8'd0;
         r_snap_locs <= 128'd0;
         Busy        <= 1'b0;
         Cell_Valid  <= 1'b0;
         Cell_Addr   <= 8'd0;
         Cell_Type   <= 2'd0;
         Frame_Done  <= 1'b0;
`ifdef SNAKE_SCAN_OVERLAP_EN
         r_cur_multi <= 1'b0;
         r_ovl_flag  <= 1'b0;
         Overlap     <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               Frame_Done <= 1'b0;
               if (Start) begin
                  r_snap_len  <= Length;
                  r_snap_food <= Food;
                  r_snap_locs <= Locations_Flat;
                  Busy        <= 1'b1;
                  Cell_Valid  <= 1'b1;
                  Cell_Addr   <= 8'd0;
                  Cell_Type   <= w_type;
                  r_state     <= ST_SCAN;
`ifdef SNAKE_SCAN_OVERLAP_EN
                  r_cur_multi <= w_multi;
                  r_ovl_flag  <= 1'b0;
                  Overlap     <= 1'b0;
`endif
               end
            end
            ST_SCAN: begin
               if (Cell_Ready) begin
`ifdef SNAKE_SCAN_OVERLAP_EN
                  r_ovl_flag <= r_ovl_flag | r_cur_multi;
`endif
                  if (Cell_Addr == LAST_ADDR) begin
                     Cell_Valid <= 1'b0;
                     Frame_Done <= 1'b1;
                     r_state    <= ST_DONE;
`ifdef SNAKE_SCAN_OVERLAP_EN
                     Overlap    <= r_ovl_flag | r_cur_multi;
`endif
                  end else begin
                     Cell_Addr <= Cell_Addr + 8'd1;
                     Cell_Type <= w_type;
`ifdef SNAKE_SCAN_OVERLAP_EN
                     r_cur_multi <= w_multi;
`endif
                  end
               end
            end
            ST_DONE: begin
               Frame_Done <= 1'b0;
               Busy       <= 1'b0;
               r_state    <= ST_IDLE;
            end
            default: begin
               Busy       <= 1'b0;
               Cell_Valid <= 1'b0;
               Frame_Done <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_grid_scan.sv
// Scoreboard bench for snake_grid_scan: expected cells are queued at Start and
// popped by a monitor on every transfer. Honours SNAKE_SCAN_OVERLAP_EN.
module tb_snake_grid_scan;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         Start = 1'b0;
   logic [3:0]   Length = 4'd0;
   logic [7:0]   Food = 8'd0;
   logic [127:0] Locations_Flat = 128'd0;
   logic         Busy;
   logic         Cell_Valid;
   logic         Cell_Ready = 1'b0;
   logic [7:0]   Cell_Addr;
   logic [1:0]   Cell_Type;
   logic         Frame_Done;
`ifdef SNAKE_SCAN_OVERLAP_EN
   logic         Overlap;
`endif

   int checks = 0;
   int failures = 0;
   int xfers = 0;
   int done_pulses = 0;
   logic [7:0] exp_addr_q[$];
   logic [1:0] exp_type_q[$];
   logic       stall_pending = 1'b0;
   logic [7:0] held_addr;
   logic [1:0] held_type;

   snake_grid_scan dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Start          (Start),
      .Length         (Length),
      .Food           (Food),
      .Locations_Flat (Locations_Flat),
      .Busy           (Busy),
      .Cell_Valid     (Cell_Valid),
      .Cell_Ready     (Cell_Ready),
      .Cell_Addr      (Cell_Addr),
      .Cell_Type      (Cell_Type),
`ifdef SNAKE_SCAN_OVERLAP_EN
      .Overlap        (Overlap),
`endif
      .Frame_Done     (Frame_Done)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [1:0] model_type(input logic [7:0] a, input logic [3:0] len,
                                             input logic [7:0] food, input logic [127:0] locs);
      logic body;
      body = 1'b0;
      for (int i = 1; i < 16; i++)
         if (i <= int'(len) && locs[127-8*i -: 8] == a) body = 1'b1;
      if (locs[127:120] == a) return 2'd2;
      else if (food == a) return 2'd3;
      else if (body) return 2'd1;
      else return 2'd0;
   endfunction

   function automatic logic model_overlap(input logic [3:0] len, input logic [127:0] locs);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 16; i++)
         for (int j = i + 1; j < 16; j++)
            if (j <= int'(len) && locs[127-8*i -: 8] == locs[127-8*j -: 8]) hit = 1'b1;
      return hit;
   endfunction

   // Monitor: pops the scoreboard on every transfer and checks hold-stability during stalls.
   always @(negedge Clk) begin
      if (Frame_Done) done_pulses++;
      if (Cell_Valid) begin
         if (stall_pending) begin
            chk("stall_addr", 32'(Cell_Addr), 32'(held_addr));
            chk("stall_type", 32'(Cell_Type), 32'(held_type));
         end
         if (Cell_Ready) begin
            xfers++;
            stall_pending = 1'b0;
            if (exp_addr_q.size() == 0) begin
               chk("extra_xfer", 32'(Cell_Addr), 32'hFFFF_FFFF);
            end else begin
               chk("cell_addr", 32'(Cell_Addr), 32'(exp_addr_q.pop_front()));
               chk("cell_type", 32'(Cell_Type), 32'(exp_type_q.pop_front()));
            end
         end else begin
            stall_pending = 1'b1;
            held_addr = Cell_Addr;
            held_type = Cell_Type;
         end
      end else begin
         stall_pending = 1'b0;
      end
   end

   task automatic run_frame(input logic [3:0] len, input logic [7:0] food, input logic [127:0] locs,
                            input int toggle_ready, input int restart_mid);
      int  d0;
      int  x0;
      logic seen;
      d0 = done_pulses;
      x0 = xfers;
      seen = 1'b0;
      Length = len;
      Food = food;
      Locations_Flat = locs;
      for (int a = 0; a < 256; a++) begin
         exp_addr_q.push_back(8'(a));
         exp_type_q.push_back(model_type(8'(a), len, food, locs));
      end
      Cell_Ready = 1'b1;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      chk("first_valid", 32'(Cell_Valid), 32'd1);
      chk("first_addr", 32'(Cell_Addr), 32'd0);
      chk("busy_scan", 32'(Busy), 32'd1);
      for (int c = 0; c < 3000; c++) begin
         if (Frame_Done) begin
            seen = 1'b1;
            break;
         end
         if (toggle_ready != 0) Cell_Ready = ~Cell_Ready;
         if (c == 5) begin
            Food = food + 8'd1;
            Locations_Flat = ~locs;
            Length = ~len;
         end
         Start = (restart_mid != 0 && c == 10) ? 1'b1 : 1'b0;
         @(posedge Clk); #1;
      end
      Start = 1'b0;
      chk("frame_done_seen", 32'(seen), 32'd1);
      chk("done_busy", 32'(Busy), 32'd1);
      chk("done_valid", 32'(Cell_Valid), 32'd0);
`ifdef SNAKE_SCAN_OVERLAP_EN
      chk("overlap", 32'(Overlap), 32'(model_overlap(len, locs)));
`endif
      @(posedge Clk); #1;
      chk("done_pulse_end", 32'(Frame_Done), 32'd0);
      chk("busy_idle", 32'(Busy), 32'd0);
      repeat (3) @(posedge Clk);
      #1;
      chk("xfer_count", 32'(xfers - x0), 32'd256);
      chk("queue_empty", 32'(exp_addr_q.size()), 32'd0);
      chk("done_count", 32'(done_pulses - d0), 32'd1);
`ifdef SNAKE_SCAN_OVERLAP_EN
      chk("overlap_hold", 32'(Overlap), 32'(model_overlap(len, locs)));
`endif
   endtask

   initial begin
      logic [127:0] locs;
      int           d0;
      logic         hit100;

      // Reset state
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_valid", 32'(Cell_Valid), 32'd0);
      chk("rst_addr", 32'(Cell_Addr), 32'd0);
      chk("rst_type", 32'(Cell_Type), 32'd0);
      chk("rst_done", 32'(Frame_Done), 32'd0);
      Reset = 1'b0;
      @(posedge Clk); #1;

      // Basic frame: head 125, body 124, food 3; unoccupied slots point at 50
      locs = '1;
      for (int i = 0; i < 16; i++) locs[127-8*i -: 8] = 8'd50;
      locs[127:120] = 8'd125;
      locs[119:112] = 8'd124;
      run_frame(4'd1, 8'd3, locs, 0, 0);
      run_frame(4'd1, 8'd3, locs, 1, 0);

      // Head, food and body all on cell 40
      locs[127:120] = 8'd40;
      locs[119:112] = 8'd40;
      run_frame(4'd1, 8'd40, locs, 0, 0);

      // Food 200 captured; live inputs change mid-frame inside run_frame
      locs[127:120] = 8'd7;
      locs[119:112] = 8'd8;
      run_frame(4'd0, 8'd200, locs, 1, 0);

      // Reset in the middle of a frame at address 100
      d0 = done_pulses;
      hit100 = 1'b0;
      for (int a = 0; a < 256; a++) begin
         exp_addr_q.push_back(8'(a));
         exp_type_q.push_back(model_type(8'(a), 4'd0, 8'd200, locs));
      end
      Length = 4'd0;
      Food = 8'd200;
      Locations_Flat = locs;
      Cell_Ready = 1'b1;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge Clk);
         if (Cell_Valid && Cell_Addr == 8'd100) begin
            hit100 = 1'b1;
            break;
         end
      end
      chk("reached_addr100", 32'(hit100), 32'd1);
      Reset = 1'b1;
      @(posedge Clk); #1;
      chk("midrst_valid", 32'(Cell_Valid), 32'd0);
      chk("midrst_busy", 32'(Busy), 32'd0);
      Reset = 1'b0;
      exp_addr_q.delete();
      exp_type_q.delete();
      repeat (4) @(posedge Clk);
      #1;
      chk("midrst_no_done", 32'(done_pulses - d0), 32'd0);
      run_frame(4'd1, 8'd200, locs, 0, 0);

      // Full length, distinct segments, extra Start during SCAN
      for (int i = 0; i < 16; i++) locs[127-8*i -: 8] = 8'(16 * i + 3);
      run_frame(4'd15, 8'd250, locs, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
